// File: rtl/change_return_sequencer.sv
// Inactivity timer and greedy change dispenser for the vending machine.
// Optional RETURN_STATS_EN adds o_returned_total (saturating coin sum).
module change_return_sequencer #(
  parameter int NUM_COINS     = 3,
  parameter int NUM_ITEMS     = 4,
  parameter int MONEY_W       = 31,
  parameter int TIME_W        = 32,
  parameter int WAIT_CYCLES   = 10,
  parameter int TRIGGER_DELAY = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_COINS-1:0]         i_input_coin,
  input  logic [NUM_ITEMS-1:0]         i_select_item,
  input  logic                         i_trigger_return,
  input  logic [NUM_COINS*MONEY_W-1:0] i_coin_value,
  input  logic [MONEY_W-1:0]           i_balance,
  output logic [NUM_COINS-1:0]         o_return_coin,
  output logic [TIME_W-1:0]            o_wait_time,
  output logic                         o_returning,
  output logic                         o_return_done,
`ifdef RETURN_STATS_EN
  output logic [MONEY_W-1:0]           o_returned_total,
`endif
  output logic [MONEY_W-1:0]           o_residue
);

  typedef enum logic [1:0] {
    S_COUNT,
    S_IDLE,
    S_RETURN,
    S_DONE
  } state_t;

  localparam logic [TIME_W-1:0] WAIT_LD =
    TIME_W'(WAIT_CYCLES);
  localparam logic [TIME_W-1:0] TRIG_LD =
    TIME_W'(TRIGGER_DELAY);

  state_t               state, state_n;
  logic [TIME_W-1:0]    wait_n;
  logic [NUM_COINS-1:0] coin_n;
  logic                 returning_n;
  logic                 done_n;
  logic [MONEY_W-1:0]   residue_n;
  logic [MONEY_W-1:0]   remaining, remaining_n;
  logic                 armed, armed_n;

  logic                 activity;
  logic [MONEY_W-1:0]   src;
  logic [NUM_COINS-1:0] pick_oh;
  logic [MONEY_W-1:0]   pick_val;
  logic                 pick_ok;

  assign activity = (|i_input_coin) | (|i_select_item);

  // Ascending coin values: the last fitting k is the largest coin.
  always_comb begin
    src      = (state == S_RETURN) ? remaining : i_balance;
    pick_oh  = '0;
    pick_val = '0;
    pick_ok  = 1'b0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (i_coin_value[k*MONEY_W +: MONEY_W] <= src) begin
        pick_oh    = '0;
        pick_oh[k] = 1'b1;
        pick_val   = i_coin_value[k*MONEY_W +: MONEY_W];
        pick_ok    = 1'b1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    wait_n      = o_wait_time;
    coin_n      = '0;
    returning_n = 1'b0;
    done_n      = 1'b0;
    residue_n   = o_residue;
    remaining_n = remaining;
    armed_n     = armed;
    unique case (state)
      S_COUNT: begin
        if (i_trigger_return && armed) begin
          if (o_wait_time > TRIG_LD)
            wait_n = TRIG_LD;
          armed_n = 1'b0;
        end else if (activity) begin
          wait_n = WAIT_LD;
        end else if (o_wait_time != '0) begin
          wait_n = o_wait_time - 1'b1;
        end else if (pick_ok) begin
          state_n     = S_RETURN;
          coin_n      = pick_oh;
          returning_n = 1'b1;
          remaining_n = i_balance - pick_val;
        end else begin
          state_n   = S_IDLE;
          residue_n = i_balance;
        end
      end
      S_IDLE: begin
        if (activity) begin
          state_n = S_COUNT;
          wait_n  = WAIT_LD;
        end
      end
      S_RETURN: begin
        if (pick_ok) begin
          coin_n      = pick_oh;
          returning_n = 1'b1;
          remaining_n = remaining - pick_val;
        end else begin
          state_n   = S_DONE;
          done_n    = 1'b1;
          residue_n = remaining;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        armed_n = 1'b1;
      end
      default: begin
        state_n = S_COUNT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_COUNT;
      o_wait_time   <= WAIT_LD;
      o_return_coin <= '0;
      o_returning   <= 1'b0;
      o_return_done <= 1'b0;
      o_residue     <= '0;
      remaining     <= '0;
      armed         <= 1'b1;
    end else begin
      state         <= state_n;
      o_wait_time   <= wait_n;
      o_return_coin <= coin_n;
      o_returning   <= returning_n;
      o_return_done <= done_n;
      o_residue     <= residue_n;
      remaining     <= remaining_n;
      armed         <= armed_n;
    end
  end

`ifdef RETURN_STATS_EN
  logic [MONEY_W-1:0] cur_val;
  logic [MONEY_W:0]   sum;

  always_comb begin
    cur_val = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (o_return_coin[k])
        cur_val = i_coin_value[k*MONEY_W +: MONEY_W];
    end
    sum = {1'b0, o_returned_total} + {1'b0, cur_val};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      o_returned_total <= '0;
    else if (sum[MONEY_W])
      o_returned_total <= '1;
    else
      o_returned_total <= sum[MONEY_W-1:0];
  end
`endif

endmodule
